sprite_rom_arbiter: RTL and testbench
=====================================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one single-port sprite ROM (24-bit RGB, registered read, 1-cycle latency) among
//  N_REQ sprite fetchers (note lanes, fret overlay, HUD). Round-robin arbitration, one read
//  issued per cycle max, responses returned in grant order through a credit-guarded FIFO
//  tagged with requester id and a transparency flag. Sits between the sprite drawers and the
//  frameRAM_* color ROMs, ahead of the pixel mux.
// PARAMETERS
//  N_REQ       4         number of requesters (>=2)
//  ADDR_W      12        requester address width (64x64 sprite = 4096 words)
//  ROM_ADDR_W  19        ROM read_address width; upper bits zero-extended
//  DATA_W      24        ROM pixel width
//  FIFO_DEPTH  4         response FIFO entries (power of 2, >=4)
//  TRANSP_KEY  24'hFF00FF color treated as transparent
// PORTS
//  Clk              in   1                  system clock, all state on posedge
//  Reset_n          in   1                  async active-low reset
//  req_valid        in   N_REQ              per-requester read request
//  req_addr         in   N_REQ*ADDR_W       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_ready        out  N_REQ              one-hot grant; accept = req_valid[i] & req_ready[i]
//  rom_addr         out  ROM_ADDR_W         registered address to ROM read_address
//  rom_data         in   DATA_W             ROM data_Out
//  rsp_valid        out  1                  FIFO head valid
//  rsp_ready        in   1                  consumer pops head when rsp_valid & rsp_ready
//  rsp_id           out  $clog2(N_REQ)      requester index of head
//  rsp_data         out  DATA_W             pixel of head
//  rsp_transparent  out  1                  rsp_data == TRANSP_KEY
//  busy             out  1                  any request in flight or FIFO non-empty
// BEHAVIOUR
//  Reset (async, Reset_n=0): req_ready=0, rom_addr=0, rsp_valid=0, rr pointer=0, stage valids
//   s1=s2=0, FIFO empty, busy=0. Assertion mid-operation discards in-flight reads and FIFO.
//  Credit: cnt = fifo_count + s1 + s2. Grant only when cnt < FIFO_DEPTH; same-cycle pop gives
//   no credit. FIFO therefore never overflows; write-when-full is illegal (assert in sim).
//  Arbitration (combinational, per cycle): scan req_valid from rr pointer upward, wrapping at
//   N_REQ; first set bit gets req_ready. At most one req_ready high. None if credit exhausted.
//   req_ready never depends on rsp_ready (no comb path rsp_ready->req_ready).
//  On accept of requester g at edge E0: rom_addr <= zero-extend(req_addr[g]); s1<=1, tag1<=g;
//   rr pointer <= (g+1) mod N_REQ. No accept: rom_addr holds, s1<=0, pointer holds.
//  E1: ROM registers data; s2<=s1, tag2<=tag1. E2: if s2, FIFO writes {tag2, rom_data}.
//  Latency: accept in cycle t -> rsp_valid high in cycle t+3 (FIFO empty, no stall).
//  Throughput: 1 accept/cycle sustained with rsp_ready held 1 and FIFO_DEPTH>=4.
//  FIFO: show-ahead; rsp_* reflect head; push and pop in same cycle legal at any occupancy
//   including full (count unchanged) and empty-with-push (pop not possible, count+1).
//  Pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  rsp_transparent combinational from head data; 0 when rsp_valid=0 (rsp_data then don't-care).
//  Order: responses emerge strictly in accept order regardless of requester.
//  req_addr must be held stable only in the accept cycle; a requester may drop req_valid
//   without acceptance (no penalty, pointer unchanged).
//  busy = s1 | s2 | (fifo_count != 0).
// TESTING
//  1 Reset: hold Reset_n=0 with req_valid=4'hF -> req_ready=0, rsp_valid=0, rom_addr=0, busy=0.
//  2 Single: req_valid=4'b0100, addr 12'h123, rsp_ready=1 -> rom_addr=19'h00123 next cycle;
//    rsp_valid in cycle t+3, rsp_id=2, rsp_data=ROM[0x123]; exactly one response.
//  3 Round-robin: req_valid=4'hF held 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle;
//    responses in same id order, one per cycle after 3-cycle fill.
//  4 Backpressure: rsp_ready=0, all requesting -> exactly 4 accepts then req_ready=0; FIFO full;
//    rsp_ready=1 for 1 cycle -> one pop, one new grant within next cycle, no data loss.
//  5 Transparency: ROM[0x010]=24'hFF00FF, ROM[0x011]=24'h00FF00 -> rsp_transparent 1 then 0.
//  6 Reset mid-flight: 3 accepts, Reset_n pulsed low at cycle t+1 -> no rsp_valid afterward,
//    busy=0, next request after release responds normally with 3-cycle latency.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: request, ROM and response signals shared by the arbiter and its neighbours
interface sprite_rom_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 12,
  parameter int ROM_ADDR_W = 19,
  parameter int DATA_W = 24
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0] req_ready;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_transparent;
  logic busy;
  modport slave (
    input req_valid, req_addr, rom_data, rsp_ready,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_transparent, busy
  );
  modport master (
    output req_valid, req_addr, rom_data, rsp_ready,
    input req_ready, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_transparent, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one registered-read sprite ROM, in-order tagged responses
module sprite_rom_arbiter #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 12,
  parameter int ROM_ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] TRANSP_KEY = 24'hFF00FF
) (
  input logic Clk,
  input logic Reset_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ID_W:0] N_C = (ID_W+1)'(N_REQ);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  logic [ID_W-1:0] rr, gnt_id, tag1, tag2, head_id;
  logic [ID_W:0] sum;
  logic [2*N_REQ-1:0] rot;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] head_data;
  logic s1, s2, found, credit, accept, push, pop, valid, full;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr, rd;
  logic [ID_W+DATA_W-1:0] mem [FIFO_DEPTH];
  // Rotating the doubled request vector by rr turns the wrap-around scan into a plain priority scan
  always_comb begin
    rot = {bus.req_valid, bus.req_valid} >> rr;
    found = 1'b0;
    gnt_id = '0;
    sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      addr_arr[k] = bus.req_addr[k*ADDR_W +: ADDR_W];
      if (!found && rot[k]) begin
        found = 1'b1;
        sum = {1'b0, rr} + (ID_W+1)'(k);
        gnt_id = ID_W'(sum >= N_C ? sum - N_C : sum);
      end
    end
  end
  // Reads already in the pipe hold a FIFO slot, so a granted read can never find the FIFO full
  assign credit = ({1'b0, count} + (CNT_W+1)'(s1) + (CNT_W+1)'(s2)) < DEPTH_C;
  assign accept = found & credit & Reset_n;
  assign valid = count != '0;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign push = s2;
  assign pop = valid & bus.rsp_ready;
  assign {head_id, head_data} = mem[rd];
  assign bus.req_ready = accept ? N_REQ'(1) << gnt_id : '0;
  assign bus.rom_addr = rom_addr;
  assign bus.rsp_valid = valid;
  assign bus.rsp_id = head_id;
  assign bus.rsp_data = head_data;
  assign bus.rsp_transparent = valid && head_data == TRANSP_KEY;
  assign bus.busy = s1 | s2 | valid;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr <= '0;
      rom_addr <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      count <= '0;
      wr <= '0;
      rd <= '0;
    end else begin
      s1 <= accept;
      s2 <= s1;
      tag2 <= tag1;
      if (accept) begin
        tag1 <= gnt_id;
        rom_addr <= ROM_ADDR_W'(addr_arr[gnt_id]);
        rr <= gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge Clk) if (push) mem[wr] <= {tag2, bus.rom_data};
  assert property (@(posedge Clk) disable iff (!Reset_n) !(push && full && !pop));
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: table vectors, corner sequences and random traffic against a queue-based model
module tb_sprite_rom_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sprite_rom_arbiter_if bus ();
  sprite_rom_arbiter dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
  logic [23:0] rom_mem [4096];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr[11:0]];
  typedef struct { int id; logic [23:0] d; int vis; } ent_t;
  ent_t q[$];
  int rr_m = 0;
  int cyc = 0;
  logic [11:0] last_addr = '0;
  int tests = 0;
  int fails = 0;
  logic [3:0] smp_ready;
  logic smp_valid, smp_transp;
  logic [1:0] smp_id;
  logic [23:0] smp_data;
  logic [18:0] smp_rom;
  typedef struct { logic [3:0] v; logic r; logic [3:0] ready; logic valid; logic [1:0] id; } vec_t;
  vec_t tbl [27];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // One clock cycle: apply inputs, compare against the model mid-cycle, advance the model
  task automatic cycle(input logic [3:0] v, input logic [47:0] a, input logic r);
    int g;
    logic hv;
    logic [23:0] hd;
    bus.req_valid = v;
    bus.req_addr = a;
    bus.rsp_ready = r;
    #4;
    g = -1;
    if (q.size() < 4)
      for (int k = 0; k < 4; k++)
        if (g < 0 && ((v >> ((rr_m + k) % 4)) & 4'd1) != 4'd0) g = (rr_m + k) % 4;
    hv = q.size() > 0 && q[0].vis <= cyc;
    hd = hv ? q[0].d : 24'h0;
    smp_ready = bus.req_ready;
    smp_valid = bus.rsp_valid;
    smp_id = bus.rsp_id;
    smp_data = bus.rsp_data;
    smp_transp = bus.rsp_transparent;
    smp_rom = bus.rom_addr;
    check("req_ready", bus.req_ready, g < 0 ? 4'b0 : 4'b1 << g);
    check("rom_addr", bus.rom_addr, {7'b0, last_addr});
    check("rsp_valid", bus.rsp_valid, hv);
    if (hv) begin
      check("rsp_id", bus.rsp_id, q[0].id);
      check("rsp_data", bus.rsp_data, hd);
    end
    check("rsp_transparent", bus.rsp_transparent, hv && hd == 24'hFF00FF);
    check("busy", bus.busy, q.size() != 0);
    if (hv && r) void'(q.pop_front());
    if (g >= 0) begin
      last_addr = a[g*12 +: 12];
      q.push_back('{g, rom_mem[last_addr], cyc + 3});
      rr_m = (g + 1) % 4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic single(input logic [3:0] v, input logic [47:0] a, input int id, input logic [11:0] ad);
    int n = 0;
    int first = -1;
    cycle(v, a, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      cycle(4'h0, a, 1'b1);
      if (k == 1) check("single_rom_addr", smp_rom, {7'b0, ad});
      if (smp_valid) begin
        n++;
        if (first < 0) first = k;
        check("single_id", smp_id, id);
        check("single_data", smp_data, rom_mem[ad]);
      end
    end
    check("single_latency", first, 3);
    check("single_count", n, 1);
  endtask
  initial begin
    logic [47:0] ta;
    logic [47:0] ra;
    int n;
    logic [1:0] tv;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 24'(i * 40503 + 7) ^ 24'(i << 11);
    rom_mem[12'h010] = 24'hFF00FF;
    rom_mem[12'h011] = 24'h00FF00;
    tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b0, 2'd0};
    tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd0};
    tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd1};
    tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd2};
    tbl[6] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd3};
    tbl[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd0};
    tbl[8] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[9] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[13] = '{4'hF, 1'b0, 4'b0010, 1'b0, 2'd0};
    tbl[14] = '{4'hF, 1'b0, 4'b0100, 1'b0, 2'd0};
    tbl[15] = '{4'hF, 1'b0, 4'b1000, 1'b1, 2'd0};
    tbl[16] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[17] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[18] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[19] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[20] = '{4'hF, 1'b0, 4'b0001, 1'b1, 2'd1};
    tbl[21] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[22] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[23] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[24] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[25] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[26] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    bus.req_valid = 4'hF;
    bus.req_addr = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_req_ready", bus.req_ready, 4'b0);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rom_addr", bus.rom_addr, 19'h0);
    check("reset_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ta = {12'h3C3, 12'h2B2, 12'h1A1, 12'h090};
    for (int i = 0; i < 27; i++) begin
      cycle(tbl[i].v, ta, tbl[i].r);
      check("tbl_req_ready", smp_ready, tbl[i].ready);
      check("tbl_rsp_valid", smp_valid, tbl[i].valid);
      if (tbl[i].valid) check("tbl_rsp_id", smp_id, tbl[i].id);
    end
    single(4'b0100, {12'h000, 12'h123, 12'h000, 12'h000}, 2, 12'h123);
    cycle(4'b0001, {36'h0, 12'h010}, 1'b1);
    cycle(4'b0001, {36'h0, 12'h011}, 1'b1);
    n = 0;
    tv = 2'b00;
    for (int k = 0; k < 6; k++) begin
      cycle(4'h0, '0, 1'b1);
      if (smp_valid) begin
        if (n < 2) tv[n] = smp_transp;
        n++;
      end
    end
    check("transp_count", n, 2);
    check("transp_first", tv[0], 1'b1);
    check("transp_second", tv[1], 1'b0);
    repeat (3) cycle(4'hF, ta, 1'b1);
    bus.req_valid = 4'h0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", bus.rsp_valid, 1'b0);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_req_ready", bus.req_ready, 4'b0);
    check("midreset_rom_addr", bus.rom_addr, 19'h0);
    q.delete();
    rr_m = 0;
    last_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    repeat (6) cycle(4'h0, ta, 1'b1);
    single(4'b0010, {12'h000, 12'h000, 12'h456, 12'h000}, 1, 12'h456);
    for (int i = 0; i < 600; i++) begin
      ra = {16'($urandom), $urandom};
      cycle(4'($urandom), ra, i < 300 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0);
    end
    repeat (12) cycle(4'h0, '0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
